logisim_top_level_shell: RTL and testbench

Bit-level top shell of a Manchester Baby (SSEM) processor core: a 32-bit accumulator machine with a 5-bit word address space held in external RAM. It fetches and executes the seven SSEM instructions and drives an external 32×32 RAM over a simple single-port interface. It also exports a buffered clock and a stop lamp. A thin wrapper (`manchester_baby`) bundles its bit-per-port interface into buses.

---
 rtl/logisim_top_level_shell.sv | 154 +++++++++++++++
 tb/tb_logisim_top_level_shell.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logisim_top_level_shell.sv
// logisim_top_level_shell
// Bit-level top shell of a Manchester Baby (SSEM) core: a 32-bit accumulator
// machine that fetches instructions from, and stores results to, an external
// 32x32 single-port RAM.
//
// Ports
//   fpgaGlobalClock           sole clock, rising edge
//   reset_i_0                 asynchronous active-high reset
//   ram_data_i_0..31          RAM read word (combinational read of ram_addr)
//   ram_data_o_0..31          RAM write word, always the accumulator
//   ram_addr_o_0..4           RAM word address
//   ram_rw_en_o_0             0 = read, 1 = write on the closing clock edge
//   stop_lamp_o_0             high while halted by STP
//   logisim_clock_tree_0_out  buffered copy of fpgaGlobalClock
//
// State      | meaning
// ST_INC     | CI <= CI + 1 (frozen here while halted)
// ST_FETCH   | PI <= RAM[CI]
// ST_EXEC    | execute PI against S = RAM[PI[4:0]]
module logisim_top_level_shell (
  input  logic fpgaGlobalClock,
  input  logic reset_i_0,
  input  logic ram_data_i_0,  input  logic ram_data_i_1,  input  logic ram_data_i_2,  input  logic ram_data_i_3,
  input  logic ram_data_i_4,  input  logic ram_data_i_5,  input  logic ram_data_i_6,  input  logic ram_data_i_7,
  input  logic ram_data_i_8,  input  logic ram_data_i_9,  input  logic ram_data_i_10, input  logic ram_data_i_11,
  input  logic ram_data_i_12, input  logic ram_data_i_13, input  logic ram_data_i_14, input  logic ram_data_i_15,
  input  logic ram_data_i_16, input  logic ram_data_i_17, input  logic ram_data_i_18, input  logic ram_data_i_19,
  input  logic ram_data_i_20, input  logic ram_data_i_21, input  logic ram_data_i_22, input  logic ram_data_i_23,
  input  logic ram_data_i_24, input  logic ram_data_i_25, input  logic ram_data_i_26, input  logic ram_data_i_27,
  input  logic ram_data_i_28, input  logic ram_data_i_29, input  logic ram_data_i_30, input  logic ram_data_i_31,
  output logic ram_data_o_0,  output logic ram_data_o_1,  output logic ram_data_o_2,  output logic ram_data_o_3,
  output logic ram_data_o_4,  output logic ram_data_o_5,  output logic ram_data_o_6,  output logic ram_data_o_7,
  output logic ram_data_o_8,  output logic ram_data_o_9,  output logic ram_data_o_10, output logic ram_data_o_11,
  output logic ram_data_o_12, output logic ram_data_o_13, output logic ram_data_o_14, output logic ram_data_o_15,
  output logic ram_data_o_16, output logic ram_data_o_17, output logic ram_data_o_18, output logic ram_data_o_19,
  output logic ram_data_o_20, output logic ram_data_o_21, output logic ram_data_o_22, output logic ram_data_o_23,
  output logic ram_data_o_24, output logic ram_data_o_25, output logic ram_data_o_26, output logic ram_data_o_27,
  output logic ram_data_o_28, output logic ram_data_o_29, output logic ram_data_o_30, output logic ram_data_o_31,
  output logic ram_addr_o_0,
  output logic ram_addr_o_1,
  output logic ram_addr_o_2,
  output logic ram_addr_o_3,
  output logic ram_addr_o_4,
  output logic ram_rw_en_o_0,
  output logic stop_lamp_o_0,
  output logic logisim_clock_tree_0_out
);

  typedef enum logic [1:0] {
    ST_INC   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [2:0] FN_JMP = 3'b000;
  localparam logic [2:0] FN_JRP = 3'b001;
  localparam logic [2:0] FN_LDN = 3'b010;
  localparam logic [2:0] FN_STO = 3'b011;
  localparam logic [2:0] FN_CMP = 3'b110;
  localparam logic [2:0] FN_STP = 3'b111;

  logic [31:0] w_ram_data;
  logic [31:0] r_a, w_a_nxt;
  logic [31:0] r_ci, w_ci_nxt;
  // Only the function field and the operand line of PI are ever observable,
  // so the ignored instruction bits are not kept.
  logic [2:0]  r_pi_fn, w_pi_fn_nxt;
  logic [4:0]  r_pi_s, w_pi_s_nxt;
  logic        r_stop, w_stop_nxt;
  state_t      r_state, w_state_nxt;
  logic [4:0]  w_addr;
  logic        w_rw_en;

  assign w_ram_data = {ram_data_i_31, ram_data_i_30, ram_data_i_29, ram_data_i_28,
                       ram_data_i_27, ram_data_i_26, ram_data_i_25, ram_data_i_24,
                       ram_data_i_23, ram_data_i_22, ram_data_i_21, ram_data_i_20,
                       ram_data_i_19, ram_data_i_18, ram_data_i_17, ram_data_i_16,
                       ram_data_i_15, ram_data_i_14, ram_data_i_13, ram_data_i_12,
                       ram_data_i_11, ram_data_i_10, ram_data_i_9,  ram_data_i_8,
                       ram_data_i_7,  ram_data_i_6,  ram_data_i_5,  ram_data_i_4,
                       ram_data_i_3,  ram_data_i_2,  ram_data_i_1,  ram_data_i_0};

  always_ff @(posedge fpgaGlobalClock or posedge reset_i_0) begin
    if (reset_i_0) begin
      r_a     <= '0;
      r_ci    <= '0;
      r_pi_fn <= '0;
      r_pi_s  <= '0;
      r_stop  <= 1'b0;
      r_state <= ST_INC;
    end else begin
      r_a     <= w_a_nxt;
      r_ci    <= w_ci_nxt;
      r_pi_fn <= w_pi_fn_nxt;
      r_pi_s  <= w_pi_s_nxt;
      r_stop  <= w_stop_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_a_nxt     = r_a;
    w_ci_nxt    = r_ci;
    w_pi_fn_nxt = r_pi_fn;
    w_pi_s_nxt  = r_pi_s;
    w_stop_nxt  = r_stop;
    w_state_nxt = r_state;
    w_addr      = r_ci[4:0];
    w_rw_en     = 1'b0;
    case (r_state)
      ST_INC: begin
        // Halt is a frozen INC state; only reset clears STOP.
        if (!r_stop) begin
          w_ci_nxt    = r_ci + 32'd1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_pi_fn_nxt = w_ram_data[15:13];
        w_pi_s_nxt  = w_ram_data[4:0];
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_addr      = r_pi_s;
        w_state_nxt = ST_INC;
        case (r_pi_fn)
          FN_JMP: w_ci_nxt = w_ram_data;
          FN_JRP: w_ci_nxt = r_ci + w_ram_data;
          FN_LDN: w_a_nxt  = 32'd0 - w_ram_data;
          FN_STO: w_rw_en  = 1'b1;
          FN_CMP: if (r_a[31]) w_ci_nxt = r_ci + 32'd1;
          FN_STP: w_stop_nxt = 1'b1;
          default: w_a_nxt = r_a - w_ram_data;  // 100 and 101 are both SUB
        endcase
      end
      default: w_state_nxt = ST_INC;
    endcase
  end

  assign {ram_addr_o_4, ram_addr_o_3, ram_addr_o_2, ram_addr_o_1, ram_addr_o_0} = w_addr;
  assign ram_rw_en_o_0 = w_rw_en;
  assign stop_lamp_o_0 = r_stop;
  assign logisim_clock_tree_0_out = fpgaGlobalClock;

  assign {ram_data_o_31, ram_data_o_30, ram_data_o_29, ram_data_o_28,
          ram_data_o_27, ram_data_o_26, ram_data_o_25, ram_data_o_24,
          ram_data_o_23, ram_data_o_22, ram_data_o_21, ram_data_o_20,
          ram_data_o_19, ram_data_o_18, ram_data_o_17, ram_data_o_16,
          ram_data_o_15, ram_data_o_14, ram_data_o_13, ram_data_o_12,
          ram_data_o_11, ram_data_o_10, ram_data_o_9,  ram_data_o_8,
          ram_data_o_7,  ram_data_o_6,  ram_data_o_5,  ram_data_o_4,
          ram_data_o_3,  ram_data_o_2,  ram_data_o_1,  ram_data_o_0} = r_a;

endmodule

// File: tb/tb_logisim_top_level_shell.sv
module tb_logisim_top_level_shell;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rdata, dout;
  logic [4:0]  addr;
  logic        rw, lamp, clk_out;

  logic [31:0] mem [32];
  logic        clr = 1'b0, ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  int          cyc, wr_count, wr_cycle;
  int          n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign rdata = mem[addr];

  logisim_top_level_shell dut (
    .fpgaGlobalClock(clk), .reset_i_0(rst),
    .ram_data_i_0(rdata[0]),   .ram_data_i_1(rdata[1]),   .ram_data_i_2(rdata[2]),   .ram_data_i_3(rdata[3]),
    .ram_data_i_4(rdata[4]),   .ram_data_i_5(rdata[5]),   .ram_data_i_6(rdata[6]),   .ram_data_i_7(rdata[7]),
    .ram_data_i_8(rdata[8]),   .ram_data_i_9(rdata[9]),   .ram_data_i_10(rdata[10]), .ram_data_i_11(rdata[11]),
    .ram_data_i_12(rdata[12]), .ram_data_i_13(rdata[13]), .ram_data_i_14(rdata[14]), .ram_data_i_15(rdata[15]),
    .ram_data_i_16(rdata[16]), .ram_data_i_17(rdata[17]), .ram_data_i_18(rdata[18]), .ram_data_i_19(rdata[19]),
    .ram_data_i_20(rdata[20]), .ram_data_i_21(rdata[21]), .ram_data_i_22(rdata[22]), .ram_data_i_23(rdata[23]),
    .ram_data_i_24(rdata[24]), .ram_data_i_25(rdata[25]), .ram_data_i_26(rdata[26]), .ram_data_i_27(rdata[27]),
    .ram_data_i_28(rdata[28]), .ram_data_i_29(rdata[29]), .ram_data_i_30(rdata[30]), .ram_data_i_31(rdata[31]),
    .ram_data_o_0(dout[0]),   .ram_data_o_1(dout[1]),   .ram_data_o_2(dout[2]),   .ram_data_o_3(dout[3]),
    .ram_data_o_4(dout[4]),   .ram_data_o_5(dout[5]),   .ram_data_o_6(dout[6]),   .ram_data_o_7(dout[7]),
    .ram_data_o_8(dout[8]),   .ram_data_o_9(dout[9]),   .ram_data_o_10(dout[10]), .ram_data_o_11(dout[11]),
    .ram_data_o_12(dout[12]), .ram_data_o_13(dout[13]), .ram_data_o_14(dout[14]), .ram_data_o_15(dout[15]),
    .ram_data_o_16(dout[16]), .ram_data_o_17(dout[17]), .ram_data_o_18(dout[18]), .ram_data_o_19(dout[19]),
    .ram_data_o_20(dout[20]), .ram_data_o_21(dout[21]), .ram_data_o_22(dout[22]), .ram_data_o_23(dout[23]),
    .ram_data_o_24(dout[24]), .ram_data_o_25(dout[25]), .ram_data_o_26(dout[26]), .ram_data_o_27(dout[27]),
    .ram_data_o_28(dout[28]), .ram_data_o_29(dout[29]), .ram_data_o_30(dout[30]), .ram_data_o_31(dout[31]),
    .ram_addr_o_0(addr[0]), .ram_addr_o_1(addr[1]), .ram_addr_o_2(addr[2]),
    .ram_addr_o_3(addr[3]), .ram_addr_o_4(addr[4]),
    .ram_rw_en_o_0(rw), .stop_lamp_o_0(lamp), .logisim_clock_tree_0_out(clk_out)
  );

  // Cycle n after reset release ends on the n-th rising edge.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // RAM model: loader port for the bench, write port for the DUT.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      wr_count <= 0;
      wr_cycle <= 0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (rw) begin
      mem[addr] <= dout;
      wr_count  <= wr_count + 1;
      wr_cycle  <= cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Enter reset and wipe RAM and write log.
  task automatic prog_begin();
    rst = 1'b1;
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic prog_go();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Return while inside cycle k (k counted from reset release).
  task automatic at_cycle(input int k);
    int g;
    g = 0;
    while (cyc < k - 1 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 2000) chk("cycle_timeout", 32'(cyc), 32'(k - 1));
    #1;
  endtask

  task automatic check_clk(input string name);
    for (int i = 0; i < 6; i++) begin
      #3;
      chk(name, {31'd0, clk_out}, {31'd0, clk});
    end
  endtask

  typedef struct {
    logic [31:0] pre;
    logic [2:0]  fn;
    logic [31:0] s;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    // line1 = LDN 20 (RAM20 = pre), line2 = fn 21 (RAM21 = s), line3 = STO 22, line4 = STP
    tbl[0] = '{32'd5,          3'b100, 32'd3,          32'hFFFF_FFF8};
    tbl[1] = '{32'd5,          3'b010, 32'd7,          32'hFFFF_FFF9};
    tbl[2] = '{32'd0,          3'b101, 32'd1,          32'hFFFF_FFFF};
    tbl[3] = '{32'h8000_0000,  3'b100, 32'd0,          32'h8000_0000};
    tbl[4] = '{32'hFFFF_FFFF,  3'b100, 32'hFFFF_FFFF,  32'h0000_0002};
    tbl[5] = '{32'd0,          3'b010, 32'd0,          32'h0000_0000};
    tbl[6] = '{32'd1,          3'b101, 32'h7FFF_FFFF,  32'h8000_0000};

    // Reset state
    #23;
    chk("rst_addr", {27'd0, addr}, 32'd0);
    chk("rst_rw", {31'd0, rw}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_lamp", {31'd0, lamp}, 32'd0);
    check_clk("clk_in_reset");

    // Arithmetic / STO / STP vectors
    for (int v = 0; v < 7; v++) begin
      prog_begin();
      poke(5'd1, 32'h0000_4014);
      poke(5'd2, {16'd0, tbl[v].fn, 13'd21});
      poke(5'd3, 32'h0000_6016);
      poke(5'd4, 32'h0000_E000);
      poke(5'd20, tbl[v].pre);
      poke(5'd21, tbl[v].s);
      prog_go();
      at_cycle(9);
      chk($sformatf("v%0d_sto_rw", v), {31'd0, rw}, 32'd1);
      chk($sformatf("v%0d_sto_addr", v), {27'd0, addr}, 32'd22);
      chk($sformatf("v%0d_sto_data", v), dout, tbl[v].exp);
      at_cycle(12);
      chk($sformatf("v%0d_lamp_c12", v), {31'd0, lamp}, 32'd0);
      at_cycle(13);
      chk($sformatf("v%0d_lamp_c13", v), {31'd0, lamp}, 32'd1);
      chk($sformatf("v%0d_mem22", v), mem[22], tbl[v].exp);
      chk($sformatf("v%0d_wr_count", v), 32'(wr_count), 32'd1);
      chk($sformatf("v%0d_wr_cycle", v), 32'(wr_cycle), 32'd9);
      at_cycle(20);
      chk($sformatf("v%0d_halt_addr", v), {27'd0, addr}, 32'd4);
      chk($sformatf("v%0d_halt_dout", v), dout, tbl[v].exp);
    end
    check_clk("clk_in_halt");

    // JMP / JRP: execution order 1 -> 7 -> 10
    prog_begin();
    poke(5'd1, 32'h0000_000A);
    poke(5'd7, 32'h0000_200B);
    poke(5'd10, 32'h0000_E006);
    poke(5'd11, 32'h0000_0002);
    prog_go();
    at_cycle(5);
    chk("jmp_fetch_addr", {27'd0, addr}, 32'd7);
    at_cycle(8);
    chk("jrp_fetch_addr", {27'd0, addr}, 32'd10);
    at_cycle(9);
    chk("jj_lamp_c9", {31'd0, lamp}, 32'd0);
    at_cycle(10);
    chk("jj_lamp_c10", {31'd0, lamp}, 32'd1);

    // CMP: negative A skips line3, zero A executes it
    for (int n = 0; n < 2; n++) begin
      prog_begin();
      poke(5'd1, 32'h0000_4014);
      poke(5'd2, 32'h0000_C000);
      poke(5'd3, 32'h0000_6016);
      poke(5'd4, 32'h0000_6017);
      poke(5'd5, 32'h0000_E000);
      poke(5'd20, (n == 0) ? 32'd1 : 32'd0);
      poke(5'd22, 32'h1234_5678);
      poke(5'd23, 32'h1234_5678);
      prog_go();
      at_cycle(20);
      chk($sformatf("cmp%0d_mem22", n), mem[22], (n == 0) ? 32'h1234_5678 : 32'd0);
      chk($sformatf("cmp%0d_mem23", n), mem[23], (n == 0) ? 32'hFFFF_FFFF : 32'd0);
      chk($sformatf("cmp%0d_wr_count", n), 32'(wr_count), (n == 0) ? 32'd1 : 32'd2);
      chk($sformatf("cmp%0d_lamp", n), {31'd0, lamp}, 32'd1);
    end

    // Wrap-around: JMP 9 with RAM9 = 30 runs line 31 then line 0
    prog_begin();
    poke(5'd1, 32'h0000_0009);
    poke(5'd9, 32'd30);
    poke(5'd31, 32'h0000_4014);
    poke(5'd0, 32'h0000_6016);
    poke(5'd20, 32'd4);
    prog_go();
    at_cycle(5);
    chk("wrap_addr31", {27'd0, addr}, 32'd31);
    at_cycle(8);
    chk("wrap_addr0", {27'd0, addr}, 32'd0);
    at_cycle(9);
    chk("wrap_sto_rw", {31'd0, rw}, 32'd1);
    at_cycle(10);
    chk("wrap_mem22", mem[22], 32'hFFFF_FFFC);

    // Reset during the STO EXEC cycle
    prog_begin();
    poke(5'd1, 32'h0000_4014);
    poke(5'd2, 32'h0000_8015);
    poke(5'd3, 32'h0000_6016);
    poke(5'd4, 32'h0000_E000);
    poke(5'd20, 32'd5);
    poke(5'd21, 32'd3);
    prog_go();
    at_cycle(9);
    chk("abort_rw_before", {31'd0, rw}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_rw_drop", {31'd0, rw}, 32'd0);
    chk("abort_addr", {27'd0, addr}, 32'd0);
    chk("abort_dout", dout, 32'd0);
    poke(5'd1, 32'h0000_6017);
    poke(5'd2, 32'h0000_E000);
    poke(5'd23, 32'h1234_5678);
    chk("abort_no_write", mem[22], 32'd0);
    chk("abort_wr_count", 32'(wr_count), 32'd0);
    prog_go();
    #1;
    chk("rel_addr", {27'd0, addr}, 32'd0);
    chk("rel_lamp", {31'd0, lamp}, 32'd0);
    at_cycle(2);
    chk("rel_fetch_addr", {27'd0, addr}, 32'd1);
    at_cycle(3);
    chk("rel_sto_rw", {31'd0, rw}, 32'd1);
    chk("rel_sto_data", dout, 32'd0);
    at_cycle(7);
    chk("rel_mem23", mem[23], 32'd0);
    chk("rel_lamp_on", {31'd0, lamp}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
